// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush scheduler for the 5-stage pipeline. It drives the load
// enables, hold and bubble controls of the PC, IF/ID, ID/EXE and EXE/MEM
// registers. It resolves three hazard classes:
//   - load-use hazards (one-cycle bubble)
//   - taken branch/jump resolved in EXE (wrong-path flush)
//   - a fixed-latency iterative mul/div unit that occupies EXE
// It also keeps saturating stall and flush statistics counters.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   id_rs, id_rt         source register fields of the instruction in ID
//   id_uses_rs/rt        ID instruction actually reads rs / rt
//   id_is_muldiv         ID instruction is a mul/div
//   exe_regwrite         EXE instruction writes a register
//   exe_mem_to_reg       EXE instruction is a load
//   exe_writereg_num     EXE destination register
//   exe_branch_taken     branch/jump in EXE resolved taken
//   pc_we, ifid_we       PC and IF/ID load enables
//   ifid_flush           IF/ID loads a NOP
//   idexe_bubble         ID/EXE loads all-zero controls
//   exe_hold             ID/EXE keeps its contents
//   exemem_bubble        EXE/MEM loads all-zero controls
//   muldiv_start         one-cycle start pulse to the mul/div unit
//   muldiv_busy          high while the mul/div occupies EXE
//   stall_cycles         saturating count of cycles with pc_we=0
//   flush_count          saturating count of branch flushes
module pipe_hazard_ctrl #(
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 6,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_is_muldiv,
    input  logic              exe_regwrite,
    input  logic              exe_mem_to_reg,
    input  logic [4:0]        exe_writereg_num,
    input  logic              exe_branch_taken,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idexe_bubble,
    output logic              exe_hold,
    output logic              exemem_bubble,
    output logic              muldiv_start,
    output logic              muldiv_busy,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_count
);

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MULDIV_LAT - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] countdown;
    logic [CNT_W-1:0] countdown_next;
    logic             load_use;
    logic             flush_event;

    // Register $0 is hardwired to zero, so a load targeting it never
    // produces a value that the ID instruction could be waiting on.
    assign load_use = exe_mem_to_reg && exe_regwrite && (exe_writereg_num != 5'd0) &&
                      ((id_uses_rs && (id_rs == exe_writereg_num)) ||
                       (id_uses_rt && (id_rt == exe_writereg_num)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            countdown <= '0;
        end else begin
            state     <= state_next;
            countdown <= countdown_next;
        end
    end

    // In RUN the branch flush outranks load-use and mul/div issue because the
    // ID instruction is on the wrong path. In BUSY the EXE slot holds the
    // mul/div, so all other hazard inputs are ignored; the last BUSY cycle
    // releases the hold so the result moves on to MEM.
    always_comb begin
        state_next     = state;
        countdown_next = countdown;
        pc_we          = 1'b1;
        ifid_we        = 1'b1;
        ifid_flush     = 1'b0;
        idexe_bubble   = 1'b0;
        exe_hold       = 1'b0;
        exemem_bubble  = 1'b0;
        muldiv_start   = 1'b0;
        muldiv_busy    = 1'b0;
        flush_event    = 1'b0;
        case (state)
            RUN: begin
                if (exe_branch_taken) begin
                    ifid_flush   = 1'b1;
                    idexe_bubble = 1'b1;
                    flush_event  = 1'b1;
                end else if (load_use) begin
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idexe_bubble = 1'b1;
                end else if (id_is_muldiv) begin
                    muldiv_start   = 1'b1;
                    state_next     = BUSY;
                    countdown_next = LAT_LAST;
                end
            end
            BUSY: begin
                muldiv_busy = 1'b1;
                if (countdown == '0) begin
                    state_next = RUN;
                end else begin
                    pc_we          = 1'b0;
                    ifid_we        = 1'b0;
                    exe_hold       = 1'b1;
                    exemem_bubble  = 1'b1;
                    countdown_next = countdown - 1'b1;
                end
            end
            default: begin
                state_next     = RUN;
                countdown_next = '0;
            end
        endcase
    end

    // Statistics counters stick at all-ones instead of wrapping so a long run
    // never reports a misleadingly small number.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_we && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (flush_event && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Scoreboard bench for pipe_hazard_ctrl (MULDIV_LAT=4, STAT_W=4). The driver
// applies one directed vector per cycle at the falling edge and queues the
// hand-computed expected outputs; an independent monitor samples the DUT
// shortly after each falling edge and compares against the queue head.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       pc_we;
        logic       ifid_we;
        logic       ifid_flush;
        logic       idexe_bubble;
        logic       exe_hold;
        logic       exemem_bubble;
        logic       muldiv_start;
        logic       muldiv_busy;
        logic [3:0] stall_cycles;
        logic [3:0] flush_count;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_is_muldiv;
    logic       exe_regwrite;
    logic       exe_mem_to_reg;
    logic [4:0] exe_writereg_num;
    logic       exe_branch_taken;
    logic       pc_we;
    logic       ifid_we;
    logic       ifid_flush;
    logic       idexe_bubble;
    logic       exe_hold;
    logic       exemem_bubble;
    logic       muldiv_start;
    logic       muldiv_busy;
    logic [3:0] stall_cycles;
    logic [3:0] flush_count;

    exp_t       exp_q[$];
    string      name_q[$];
    int         total;
    int         bad;

    pipe_hazard_ctrl #(
        .MULDIV_LAT(4),
        .CNT_W     (6),
        .STAT_W    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_is_muldiv    (id_is_muldiv),
        .exe_regwrite    (exe_regwrite),
        .exe_mem_to_reg  (exe_mem_to_reg),
        .exe_writereg_num(exe_writereg_num),
        .exe_branch_taken(exe_branch_taken),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .ifid_flush      (ifid_flush),
        .idexe_bubble    (idexe_bubble),
        .exe_hold        (exe_hold),
        .exemem_bubble   (exemem_bubble),
        .muldiv_start    (muldiv_start),
        .muldiv_busy     (muldiv_busy),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds an expected-output record: controls, then the counter values
    // visible during the cycle (before the next rising edge updates them).
    function automatic exp_t ex(input logic pc, input logic ifid, input logic fl,
                                input logic bub, input logic hold, input logic emb,
                                input logic st, input logic busy,
                                input logic [3:0] sc, input logic [3:0] fc);
        exp_t e;
        e.pc_we         = pc;
        e.ifid_we       = ifid;
        e.ifid_flush    = fl;
        e.idexe_bubble  = bub;
        e.exe_hold      = hold;
        e.exemem_bubble = emb;
        e.muldiv_start  = st;
        e.muldiv_busy   = busy;
        e.stall_cycles  = sc;
        e.flush_count   = fc;
        return e;
    endfunction

    // Drives one cycle of inputs at the falling edge and queues the expectation.
    task automatic applyStimulus(input string nm, input logic r,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt, input logic md,
                                 input logic rw, input logic m2r, input logic [4:0] wn,
                                 input logic bt, input exp_t e);
        @(negedge clk);
        rst              = r;
        id_rs            = rs;
        id_rt            = rt;
        id_uses_rs       = urs;
        id_uses_rt       = urt;
        id_is_muldiv     = md;
        exe_regwrite     = rw;
        exe_mem_to_reg   = m2r;
        exe_writereg_num = wn;
        exe_branch_taken = bt;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic checkOutput(input string nm, input exp_t e);
        exp_t act;
        act.pc_we         = pc_we;
        act.ifid_we       = ifid_we;
        act.ifid_flush    = ifid_flush;
        act.idexe_bubble  = idexe_bubble;
        act.exe_hold      = exe_hold;
        act.exemem_bubble = exemem_bubble;
        act.muldiv_start  = muldiv_start;
        act.muldiv_busy   = muldiv_busy;
        act.stall_cycles  = stall_cycles;
        act.flush_count   = flush_count;
        total++;
        if (act !== e) begin
            bad++;
            $display("[TB] FAIL %s: got pc=%b ifid=%b fl=%b bub=%b hold=%b emb=%b st=%b busy=%b sc=%0d fc=%0d, want pc=%b ifid=%b fl=%b bub=%b hold=%b emb=%b st=%b busy=%b sc=%0d fc=%0d",
                     nm, act.pc_we, act.ifid_we, act.ifid_flush, act.idexe_bubble,
                     act.exe_hold, act.exemem_bubble, act.muldiv_start, act.muldiv_busy,
                     act.stall_cycles, act.flush_count,
                     e.pc_we, e.ifid_we, e.ifid_flush, e.idexe_bubble,
                     e.exe_hold, e.exemem_bubble, e.muldiv_start, e.muldiv_busy,
                     e.stall_cycles, e.flush_count);
        end
    endtask

    // Monitor: samples 2 time units after each falling edge, well away from
    // the rising edge, and checks whatever the driver queued for that cycle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                checkOutput(name_q.pop_front(), exp_q.pop_front());
            end
        end
    end

    initial begin
        int wait_cycles;
        total            = 0;
        bad              = 0;
        rst              = 1'b1;
        id_rs            = 5'd0;
        id_rt            = 5'd0;
        id_uses_rs       = 1'b0;
        id_uses_rt       = 1'b0;
        id_is_muldiv     = 1'b0;
        exe_regwrite     = 1'b0;
        exe_mem_to_reg   = 1'b0;
        exe_writereg_num = 5'd0;
        exe_branch_taken = 1'b0;

        // Reset state, then 10 hazard-free cycles.
        applyStimulus("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,0, 0, 0));
        for (int i = 0; i < 10; i++)
            applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,0, 0, 0));

        // Load-use on rs, then cases that must not stall, then load-use on rt.
        applyStimulus("lu_rs",      0, 8, 3, 1, 1, 0, 1, 1, 8, 0, ex(0,0,0,1,0,0,0,0, 0, 0));
        applyStimulus("lu_after",   0, 8, 3, 1, 1, 0, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,0, 1, 0));
        applyStimulus("lu_wn0",     0, 0, 3, 1, 1, 0, 1, 1, 0, 0, ex(1,1,0,0,0,0,0,0, 1, 0));
        applyStimulus("lu_nouse",   0, 8, 3, 0, 1, 0, 1, 1, 8, 0, ex(1,1,0,0,0,0,0,0, 1, 0));
        applyStimulus("lu_norw",    0, 8, 3, 1, 1, 0, 0, 1, 8, 0, ex(1,1,0,0,0,0,0,0, 1, 0));
        applyStimulus("lu_noload",  0, 8, 3, 1, 1, 0, 1, 0, 8, 0, ex(1,1,0,0,0,0,0,0, 1, 0));
        applyStimulus("lu_rt",      0, 2, 9, 1, 1, 0, 1, 1, 9, 0, ex(0,0,0,1,0,0,0,0, 1, 0));
        applyStimulus("lu_rt_aft",  0, 2, 9, 1, 1, 0, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,0, 2, 0));

        // Branch flush with load-use and mul/div also present: flush wins.
        applyStimulus("br_flush",   0, 8, 3, 1, 0, 1, 1, 1, 8, 1, ex(1,1,1,1,0,0,0,0, 2, 0));
        applyStimulus("br_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,0, 2, 1));

        // Mul/div issue and 4 BUSY cycles; branch in BUSY must be ignored, and a
        // mul/div waiting in ID during the last BUSY cycle issues one cycle later.
        applyStimulus("md_issue",   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ex(1,1,0,0,0,0,1,0, 2, 1));
        applyStimulus("md_busy1",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(0,0,0,0,1,1,0,1, 2, 1));
        applyStimulus("md_busy2",   0, 8, 0, 1, 0, 1, 1, 1, 8, 0, ex(0,0,0,0,1,1,0,1, 3, 1));
        applyStimulus("md_busy3",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,1,1,0,1, 4, 1));
        applyStimulus("md_last",    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,1, 5, 1));

        // Second mul/div issues from RUN, then reset hits in the 2nd BUSY cycle.
        applyStimulus("md2_issue",  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ex(1,1,0,0,0,0,1,0, 5, 1));
        applyStimulus("md2_busy1",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,1,1,0,1, 5, 1));
        applyStimulus("md2_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,0, 0, 0));
        applyStimulus("post_rst1",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,0, 0, 0));
        applyStimulus("post_rst2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,0, 0, 0));

        // 20 consecutive load-use cycles: the 4-bit stall counter sticks at 15.
        for (int k = 0; k < 20; k++)
            applyStimulus("sat_lu", 0, 8, 0, 1, 0, 0, 1, 1, 8, 0,
                          ex(0,0,0,1,0,0,0,0, (k > 15) ? 4'd15 : 4'(k), 0));
        applyStimulus("sat_hold",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,0, 15, 0));
        applyStimulus("sat_hold2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,0, 15, 0));

        // Bounded drain of the scoreboard.
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        #3;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It drives the write-enable, hold and bubble controls of the PC, IF/ID, ID/EXE and EXE/MEM registers. It resolves three hazard classes:
- load-use (one-cycle bubble)
- taken branch/jump resolved in EXE (wrong-path flush)
- a fixed-latency iterative mul/div unit that occupies EXE for MULDIV_LAT cycles

It also keeps saturating stall and flush statistics counters.

Parameters:
MULDIV_LAT, 32, cycles the mul/div instruction occupies EXE after issue (legal range 2..63)
CNT_W, 6, width of the mul/div countdown counter
STAT_W, 16, width of each statistics counter

Ports:
clk  in  1  clock
rst  in  1  reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_is_muldiv  in  1  ID instruction is mul/div
exe_regwrite  in  1  EXE instruction writes a register
exe_mem_to_reg  in  1  EXE instruction is a load
exe_writereg_num  in  5  EXE destination register
exe_branch_taken  in  1  branch/jump in EXE resolved taken
pc_we  out  1  PC register load enable
ifid_we  out  1  IF/ID register load enable
ifid_flush  out  1  IF/ID register loads a NOP
idexe_bubble  out  1  ID/EXE register loads all-zero controls
exe_hold  out  1  ID/EXE register keeps its contents
exemem_bubble  out  1  EXE/MEM register loads all-zero controls
muldiv_start  out  1  one-cycle start pulse to the mul/div unit
muldiv_busy  out  1  high while in BUSY
stall_cycles  out  STAT_W  saturating count of cycles with pc_we=0
flush_count  out  STAT_W  saturating count of flush events

Behaviour:
- Reset rst: asynchronous, active-high. Clock clk: all state updates on the rising edge.
- Reset values:
  - state=RUN, countdown=0, stall_cycles=0, flush_count=0.
  - Combinational outputs evaluate as RUN with no hazard: pc_we=1, ifid_we=1, all other controls 0.
- Control outputs are combinational from state and current inputs; the pipeline registers act on them at the next edge.
- Load-use hazard LU = exe_mem_to_reg & exe_regwrite & (exe_writereg_num!=0) & ((id_uses_rs & id_rs==exe_writereg_num) | (id_uses_rt & id_rt==exe_writereg_num)).
- State RUN, priority order:
  1. exe_branch_taken=1 (flush):
     - outputs: pc_we=1, ifid_we=1, ifid_flush=1, idexe_bubble=1.
     - LU and id_is_muldiv are ignored because the ID instruction is wrong-path.
     - muldiv_start=0; flush_count+1 at the edge.
  2. LU=1 (load-use stall):
     - outputs: pc_we=0, ifid_we=0, idexe_bubble=1.
     - stall_cycles+1.
     - Lasts exactly one cycle; forwarding covers the rest. The next cycle re-evaluates with the load in MEM, so LU=0.
  3. id_is_muldiv=1:
     - outputs: muldiv_start=1, pc_we=1, ifid_we=1.
     - At the edge: state→BUSY, countdown=MULDIV_LAT-1.
  4. Otherwise: pc_we=1, ifid_we=1, all other controls 0.
- State BUSY:
  - outputs: pc_we=0, ifid_we=0, exe_hold=1, exemem_bubble=1, muldiv_busy=1.
  - stall_cycles+1 each cycle.
  - countdown decrements every cycle.
  - In the cycle with countdown==0: exe_hold=0 and exemem_bubble=0, so the result passes to MEM; pc_we=1 and ifid_we=1; state→RUN at the edge.
  - BUSY therefore lasts MULDIV_LAT cycles, with MULDIV_LAT-1 stall cycles.
  - exe_branch_taken, LU and id_is_muldiv are ignored in BUSY (EXE holds a non-branch). A mul/div waiting in ID issues from RUN on the next cycle.
- Statistics counters saturate at 2^STAT_W-1 and never wrap.
- Reset asserted mid-BUSY: immediately returns to RUN, muldiv_busy=0, countdown=0, statistics cleared.
- exe_writereg_num=0 never causes a load-use stall.
- Simultaneous branch and load-use: the flush wins and no stall cycle is counted.

Test Plan:
- Reset release, no hazards, 10 cycles → pc_we=ifid_we=1 every cycle, all other controls 0, stall_cycles=0.
- Load-use hazard: EXE lw to $8 (mem_to_reg=1, regwrite=1, wn=8), ID add using rs=8 → exactly one cycle of pc_we=0, ifid_we=0, idexe_bubble=1; stall_cycles=1; same setup with wn=0 → no stall.
- Branch flush: exe_branch_taken=1 together with LU=1 and id_is_muldiv=1 → ifid_flush=1, idexe_bubble=1, pc_we=1, muldiv_start=0; flush_count=1, stall_cycles unchanged.
- Mul/div with MULDIV_LAT=4: id_is_muldiv=1 in RUN →
  - muldiv_start pulses 1 cycle;
  - muldiv_busy high 4 cycles;
  - exe_hold=1 for the first 3 of those cycles, then releases;
  - stall_cycles=3; returns to RUN.
- Mul/div with MULDIV_LAT=4, rst asserted on the 2nd BUSY cycle → outputs return to reset values asynchronously; after rst release the pipeline runs with no residual hold.
- Saturation with STAT_W=4: force 20 stall cycles → stall_cycles holds 15.
